// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous data memory.
// Port 0 is the CPU load/store unit, port 1 the loader/debug port; read data returns one cycle after grant.
module dmem_arbiter #(
   parameter int AW         = 32,
   parameter int DEPTH_LOG2 = 12,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [AW-1:0]         m0_addr,
   input  logic [31:0]           m0_wdata,
   input  logic [3:0]            m0_wstrb,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [31:0]           m0_rdata,

   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [AW-1:0]         m1_addr,
   input  logic [31:0]           m1_wdata,
   input  logic [3:0]            m1_wstrb,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [31:0]           m1_rdata,

   output logic                  mem_en,
   output logic [3:0]            mem_we,
   output logic [DEPTH_LOG2-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,

   output logic [CNT_W-1:0]      conflict_cnt
);

   // Handshake: a requester holds req (with stable we/addr/wdata/wstrb) until it sees gnt in
   // the same cycle; gnt means the access was issued to memory that cycle. A granted read
   // answers with a one-cycle rvalid pulse on the issuing port exactly one cycle later.

   logic last_gnt;
   logic rd_pend;
   logic rd_owner;
   logic pick1;
   logic any_gnt;
   logic sel_we;
   logic unused_addr_bits;

   always_comb begin
      pick1 = 1'b0;
      if (m0_req && m1_req)
         pick1 = ~last_gnt;
      else
         pick1 = m1_req;
   end

   assign any_gnt = (m0_req | m1_req) & ~rst;
   assign m0_gnt  = any_gnt & ~pick1;
   assign m1_gnt  = any_gnt & pick1;
   assign sel_we  = pick1 ? m1_we : m0_we;

   assign mem_en    = any_gnt;
   assign mem_we    = (any_gnt && sel_we) ? (pick1 ? m1_wstrb : m0_wstrb) : 4'b0000;
   assign mem_addr  = pick1 ? m1_addr[DEPTH_LOG2+1:2] : m0_addr[DEPTH_LOG2+1:2];
   assign mem_wdata = pick1 ? m1_wdata : m0_wdata;

   // Gating with rst kills a response that was already in flight when reset arrived.
   assign m0_rvalid = rd_pend & ~rd_owner & ~rst;
   assign m1_rvalid = rd_pend & rd_owner & ~rst;
   assign m0_rdata  = mem_rdata;
   assign m1_rdata  = mem_rdata;

   assign unused_addr_bits = ^{m0_addr[AW-1:DEPTH_LOG2+2], m0_addr[1:0],
                               m1_addr[AW-1:DEPTH_LOG2+2], m1_addr[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt     <= 1'b1;
         rd_pend      <= 1'b0;
         rd_owner     <= 1'b0;
         conflict_cnt <= '0;
      end else begin
         if (any_gnt)
            last_gnt <= pick1;
         rd_pend <= any_gnt & ~sel_we;
         if (any_gnt && !sel_we)
            rd_owner <= pick1;
         if (m0_req && m1_req && (conflict_cnt != {CNT_W{1'b1}}))
            conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of per-cycle vectors plus hand-written reset/saturation sequences.
// A second instance with a 3-bit counter shares all inputs to observe saturation.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [15:0] conflict_cnt;

   logic        s_m0_gnt, s_m0_rvalid, s_m1_gnt, s_m1_rvalid;
   logic [31:0] s_m0_rdata, s_m1_rdata;
   logic        s_mem_en;
   logic [3:0]  s_mem_we;
   logic [11:0] s_mem_addr;
   logic [31:0] s_mem_wdata;
   logic [2:0]  s_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
   );

   dmem_arbiter #(.AW(32), .DEPTH_LOG2(12), .CNT_W(3)) dut_sat (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_gnt(s_m0_gnt), .m0_rvalid(s_m0_rvalid), .m0_rdata(s_m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_gnt(s_m1_gnt), .m1_rvalid(s_m1_rvalid), .m1_rdata(s_m1_rdata),
      .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .mem_rdata(mem_rdata), .conflict_cnt(s_cnt)
   );

   // Single-port synchronous memory; known words are loaded whenever reset is held.
   logic [31:0] mem [0:4095];
   always @(posedge clk) begin
      if (rst) begin
         mem[4] <= 32'hDEADBEEF;
         mem[8] <= 32'h11223344;
      end else if (mem_en) begin
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         mem_rdata <= mem[mem_addr];
      end
   end

   typedef struct {
      logic        r0, w0;
      logic [31:0] a0, d0;
      logic [3:0]  s0;
      logic        r1, w1;
      logic [31:0] a1, d1;
      logic [3:0]  s1;
      logic        g0, g1, en;
      logic [3:0]  mwe;
      logic [11:0] maddr;
      logic        v0, v1;
      logic [31:0] rd;
      logic [15:0] cnt;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r0, w0, input logic [31:0] a0, d0, input logic [3:0] s0,
                      input logic r1, w1, input logic [31:0] a1, d1, input logic [3:0] s1,
                      input logic g0, g1, en, input logic [3:0] mwe, input logic [11:0] maddr,
                      input logic v0, v1, input logic [31:0] rd, input logic [15:0] cnt);
      vec_t v;
      v = '{r0, w0, a0, d0, s0, r1, w1, a1, d1, s1, g0, g1, en, mwe, maddr, v0, v1, rd, cnt};
      vq.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r0, w0, input logic [31:0] a0, d0, input logic [3:0] s0,
                        input logic r1, w1, input logic [31:0] a1, d1, input logic [3:0] s1);
      m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0; m0_wstrb = s0;
      m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_wstrb = s1;
   endtask

   function automatic logic [31:0] sat7(input int c);
      return (c > 7) ? 32'd7 : 32'(c);
   endfunction

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset held with both requests up: nothing may be granted.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         drive(1, 0, 32'h10, 0, 0, 1, 0, 32'h20, 0, 0);
         #2;
         check("rst_g0", m0_gnt, 0);
         check("rst_g1", m1_gnt, 0);
         check("rst_en", mem_en, 0);
         check("rst_cnt", conflict_cnt, 0);
      end

      //   r w addr    wdata         strb    r w addr    wdata         strb     g0 g1 en we      maddr   v0 v1 rdata         cnt
      for (int i = 0; i < 5; i++)
         add(0,0,32'h0, 32'h0,       4'h0,   0,0,32'h0, 32'h0,        4'h0,    0,0,0, 4'h0,   12'h0,  0,0, 32'h0,        16'd0);
      add(1,0,32'h10,32'h0,       4'h0,   0,0,32'h0, 32'h0,        4'h0,    1,0,1, 4'h0,   12'h004,0,0, 32'h0,        16'd0);
      add(0,0,32'h0, 32'h0,       4'h0,   0,0,32'h0, 32'h0,        4'h0,    0,0,0, 4'h0,   12'h0,  1,0, 32'hDEADBEEF, 16'd0);
      add(0,0,32'h0, 32'h0,       4'h0,   1,1,32'h22,32'h00AB0000, 4'b0100, 0,1,1, 4'b0100,12'h008,0,0, 32'h0,        16'd0);
      add(0,0,32'h0, 32'h0,       4'h0,   0,0,32'h0, 32'h0,        4'h0,    0,0,0, 4'h0,   12'h0,  0,0, 32'h0,        16'd0);
      add(1,0,32'h20,32'h0,       4'h0,   0,0,32'h0, 32'h0,        4'h0,    1,0,1, 4'h0,   12'h008,0,0, 32'h0,        16'd0);
      add(0,0,32'h0, 32'h0,       4'h0,   0,0,32'h0, 32'h0,        4'h0,    0,0,0, 4'h0,   12'h0,  1,0, 32'h11AB3344, 16'd0);
      add(0,0,32'h0, 32'h0,       4'h0,   1,0,32'h10,32'h0,        4'h0,    0,1,1, 4'h0,   12'h004,0,0, 32'h0,        16'd0);
      // Sustained conflict: grants alternate 0,1,... with responses one cycle behind.
      add(1,0,32'h10,32'h0,       4'h0,   1,0,32'h20,32'h0,        4'h0,    1,0,1, 4'h0,   12'h004,0,1, 32'hDEADBEEF, 16'd0);
      add(1,0,32'h10,32'h0,       4'h0,   1,0,32'h20,32'h0,        4'h0,    0,1,1, 4'h0,   12'h008,1,0, 32'hDEADBEEF, 16'd1);
      add(1,0,32'h10,32'h0,       4'h0,   1,0,32'h20,32'h0,        4'h0,    1,0,1, 4'h0,   12'h004,0,1, 32'h11AB3344, 16'd2);
      add(1,0,32'h10,32'h0,       4'h0,   1,0,32'h20,32'h0,        4'h0,    0,1,1, 4'h0,   12'h008,1,0, 32'hDEADBEEF, 16'd3);
      add(1,0,32'h10,32'h0,       4'h0,   1,0,32'h20,32'h0,        4'h0,    1,0,1, 4'h0,   12'h004,0,1, 32'h11AB3344, 16'd4);
      add(1,0,32'h10,32'h0,       4'h0,   1,0,32'h20,32'h0,        4'h0,    0,1,1, 4'h0,   12'h008,1,0, 32'hDEADBEEF, 16'd5);
      add(0,0,32'h0, 32'h0,       4'h0,   0,0,32'h0, 32'h0,        4'h0,    0,0,0, 4'h0,   12'h0,  0,1, 32'h11AB3344, 16'd6);
      // Zero-strobe write is granted but leaves memory alone.
      add(1,1,32'h10,32'hFFFFFFFF,4'h0,   0,0,32'h0, 32'h0,        4'h0,    1,0,1, 4'h0,   12'h004,0,0, 32'h0,        16'd6);
      add(0,0,32'h0, 32'h0,       4'h0,   0,0,32'h0, 32'h0,        4'h0,    0,0,0, 4'h0,   12'h0,  0,0, 32'h0,        16'd6);
      add(1,0,32'h10,32'h0,       4'h0,   0,0,32'h0, 32'h0,        4'h0,    1,0,1, 4'h0,   12'h004,0,0, 32'h0,        16'd6);
      add(0,0,32'h0, 32'h0,       4'h0,   0,0,32'h0, 32'h0,        4'h0,    0,0,0, 4'h0,   12'h0,  1,0, 32'hDEADBEEF, 16'd6);

      @(negedge clk);
      rst = 1'b0;
      foreach (vq[i]) begin
         if (i != 0) @(negedge clk);
         drive(vq[i].r0, vq[i].w0, vq[i].a0, vq[i].d0, vq[i].s0,
               vq[i].r1, vq[i].w1, vq[i].a1, vq[i].d1, vq[i].s1);
         #2;
         check($sformatf("v%0d_g0", i), m0_gnt, vq[i].g0);
         check($sformatf("v%0d_g1", i), m1_gnt, vq[i].g1);
         check($sformatf("v%0d_en", i), mem_en, vq[i].en);
         if (vq[i].en) begin
            check($sformatf("v%0d_mem_we", i), mem_we, vq[i].mwe);
            check($sformatf("v%0d_mem_addr", i), mem_addr, vq[i].maddr);
            check($sformatf("v%0d_mem_wdata", i), mem_wdata, vq[i].g0 ? vq[i].d0 : vq[i].d1);
         end
         check($sformatf("v%0d_rv0", i), m0_rvalid, vq[i].v0);
         check($sformatf("v%0d_rv1", i), m1_rvalid, vq[i].v1);
         if (vq[i].v0) check($sformatf("v%0d_rdata0", i), m0_rdata, vq[i].rd);
         if (vq[i].v1) check($sformatf("v%0d_rdata1", i), m1_rdata, vq[i].rd);
         check($sformatf("v%0d_cnt", i), conflict_cnt, vq[i].cnt);
         check($sformatf("v%0d_sat_cnt", i), s_cnt, sat7(int'(vq[i].cnt)));
      end

      // Saturation: fresh reset, then both ports request for 10 cycles.
      @(negedge clk);
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i != 0) @(negedge clk);
         drive(1, 0, 32'h10, 0, 0, 1, 0, 32'h20, 0, 0);
         #2;
         check($sformatf("sat%0d_g0", i), m0_gnt, (i % 2 == 0) ? 1 : 0);
         check($sformatf("sat%0d_g1", i), m1_gnt, (i % 2 == 1) ? 1 : 0);
         check($sformatf("sat%0d_cnt", i), conflict_cnt, i);
         check($sformatf("sat%0d_sat_cnt", i), s_cnt, sat7(i));
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      check("sat_end_cnt", conflict_cnt, 10);
      check("sat_end_sat_cnt", s_cnt, 7);
      check("sat_end_rv1", m1_rvalid, 1);
      @(negedge clk);
      #2;
      check("sat_hold_sat_cnt", s_cnt, 7);

      // Reset lands in the cycle a read response would appear.
      @(negedge clk);
      drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
      #2;
      check("mid_g0", m0_gnt, 1);
      @(negedge clk);
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      check("mid_rst_rv0", m0_rvalid, 0);
      check("mid_rst_rv1", m1_rvalid, 0);
      @(negedge clk);
      rst = 1'b0;
      #2;
      check("mid_after_rv0", m0_rvalid, 0);
      check("mid_after_rv1", m1_rvalid, 0);
      check("mid_after_cnt", conflict_cnt, 0);
      @(negedge clk);
      drive(1, 0, 32'h10, 0, 0, 1, 0, 32'h20, 0, 0);
      #2;
      check("mid_tie_g0", m0_gnt, 1);
      check("mid_tie_g1", m1_gnt, 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      check("mid_tie_rv0", m0_rvalid, 1);
      check("mid_tie_rdata0", m0_rdata, 32'hDEADBEEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
